deconv_accum_buffer: RTL and testbench

DECONV_ACCUM_BUFFER -- requirements
Module: deconv_accum_buffer

---
 rtl/deconv_accum_buffer.sv | 197 +++++++++++++++++++
 tb/tb_deconv_accum_buffer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deconv_accum_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : deconv_accum_buffer                                        |
// | Description : Accumulates partial products from an upstream deconv2D     |
// |               engine into an N*K x N*K feature-map buffer, then drains   |
// |               the valid out_dim x out_dim region row-major through a     |
// |               ready/valid port. Draining zeroes each entry as it goes,   |
// |               and the final beat clears the rest of the buffer.          |
// | Option      : DECONV_ACC_SAT_EN -- if defined, accumulation saturates at |
// |               2^ACC_W-1. Otherwise it wraps. Overflow sets ovf in both.  |
// | Ports       : clk, rst        clock, synchronous active-high reset       |
// |               stride          deconv stride, latched on frame start      |
// |               in_valid/addr/data   partial-product input (no backpressure)|
// |               frame_last      end-of-contributions pulse                 |
// |               out_valid/ready/data/addr/last   drain stream              |
// |               busy            ACCUM or DRAIN active                      |
// |               ovf, drop       sticky overflow / discarded-beat flags     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module deconv_accum_buffer #(
  parameter  int N     = 2,
  parameter  int K     = 3,
  parameter  int ACC_W = 16,
  parameter  int AW    = $clog2(N*K*N*K),
  localparam int SW    = (K > 1) ? $clog2(K) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW-1:0]    stride,
  input  logic             in_valid,
  input  logic [AW-1:0]    in_addr,
  input  logic [7:0]       in_data,
  input  logic             frame_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [AW-1:0]    out_addr,
  output logic             out_last,
  output logic             busy,
  output logic             ovf,
  output logic             drop
);

  localparam int              DIM     = N*K;
  localparam int              DEPTH   = DIM*DIM;
  localparam int              CW      = $clog2(DIM+1);
  localparam logic [AW-1:0]   DIM_A   = AW'(DIM);
  localparam logic [AW:0]     DEPTH_A = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   mem_q [DEPTH];
  logic [ACC_W-1:0]   mem_d [DEPTH];
  logic [CW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [CW-1:0]      out_dim_q, out_dim_d;
  logic               ovf_q, ovf_d;
  logic               drop_q, drop_d;

  logic               addr_ok;
  logic [AW-1:0]      acc_idx;
  logic [ACC_W:0]     sum;
  logic [AW-1:0]      scan_addr;
  logic               col_end;
  logic               row_end;
  logic               scan_end;
  int                 stride_eff;
  int                 dim_calc;

  // Scan position and end-of-row / end-of-frame detection.
  always_comb begin
    scan_addr = AW'(row_q) * DIM_A + AW'(col_q);
    col_end   = (col_q == out_dim_q - 1'b1);
    row_end   = (row_q == out_dim_q - 1'b1);
    scan_end  = col_end && row_end;
  end

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    row_d     = row_q;
    col_d     = col_q;
    out_dim_d = out_dim_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;

    // Out-of-range addresses are steered to entry 0 for the read so the
    // adder never sees an undefined operand; the write is suppressed below.
    addr_ok = ({1'b0, in_addr} < DEPTH_A);
    acc_idx = addr_ok ? in_addr : '0;
    sum     = {1'b0, mem_q[acc_idx]} + (ACC_W+1)'(in_data);

    // A zero stride is treated as 1; the output extent never exceeds the buffer.
    stride_eff = (stride == '0) ? 1 : int'(stride);
    dim_calc   = (N - 1) * stride_eff + K;
    if (dim_calc > DIM) begin
      dim_calc = DIM;
    end

    // Read-modify-write in a single cycle straight off the register array,
    // so consecutive beats to one address chain without a hazard.
    if (in_valid && (state_q != DRAIN)) begin
      if (!addr_ok) begin
        drop_d = 1'b1;
      end else begin
        if (sum[ACC_W]) begin
          ovf_d = 1'b1;
        end
`ifdef DECONV_ACC_SAT_EN
        mem_d[acc_idx] = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        mem_d[acc_idx] = sum[ACC_W-1:0];
`endif
      end
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          out_dim_d = CW'(dim_calc);
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        if (frame_last) begin
          row_d   = '0;
          col_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (in_valid) begin
          drop_d = 1'b1;
        end
        if (out_ready) begin
          mem_d[scan_addr] = '0;
          if (scan_end) begin
            // Clears any entries written outside the scanned region.
            for (int i = 0; i < DEPTH; i++) begin
              mem_d[i] = '0;
            end
            row_d   = '0;
            col_d   = '0;
            state_d = IDLE;
          end else if (col_end) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mem_q     <= '{default: '0};
      row_q     <= '0;
      col_q     <= '0;
      out_dim_q <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      row_q     <= row_d;
      col_q     <= col_d;
      out_dim_q <= out_dim_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  // Drain outputs depend only on registered state, so they stay stable
  // for as long as out_ready is held low.
  always_comb begin
    out_valid = (state_q == DRAIN);
    out_addr  = out_valid ? scan_addr : '0;
    out_data  = out_valid ? mem_q[scan_addr] : '0;
    out_last  = out_valid && scan_end;
    busy      = (state_q != IDLE);
    ovf       = ovf_q;
    drop      = drop_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_deconv_accum_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_deconv_accum_buffer                                     |
// | Description : Directed bench for deconv_accum_buffer (N=2, K=3, ACC_W=8) |
// |               with a reference buffer model and an expected-beat queue.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_deconv_accum_buffer;

  localparam int N     = 2;
  localparam int K     = 3;
  localparam int ACC_W = 8;
  localparam int DIM   = N*K;
  localparam int DEPTH = DIM*DIM;
  localparam int AW    = 6;
`ifdef DECONV_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       stride = 2'd0;
  logic             in_valid = 1'b0;
  logic [AW-1:0]    in_addr = '0;
  logic [7:0]       in_data = '0;
  logic             frame_last = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [ACC_W-1:0] out_data;
  logic [AW-1:0]    out_addr;
  logic             out_last;
  logic             busy;
  logic             ovf;
  logic             drop;

  deconv_accum_buffer #(.N(N), .K(K), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .stride     (stride),
    .in_valid   (in_valid),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .frame_last (frame_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy),
    .ovf        (ovf),
    .drop       (drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    model[DEPTH];
  int    frame_dim = 0;
  bit    in_frame  = 1'b0;
  int    passed    = 0;
  int    total     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
    in_frame = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_clear();
  endtask

  // One input beat; returns at the following negedge.
  task automatic send(input int a, input int d);
    int s;
    in_valid = 1'b1;
    in_addr  = AW'(a);
    in_data  = 8'(d);
    if (!in_frame) begin
      in_frame  = 1'b1;
      s         = (stride == 2'd0) ? 1 : int'(stride);
      frame_dim = (N - 1) * s + K;
      if (frame_dim > DIM) frame_dim = DIM;
    end
    if (a < DEPTH) begin
      model[a] = model[a] + d;
      if (model[a] > 255) model[a] = SAT ? 255 : model[a] - 256;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Pulse frame_last; queue the expected drain sequence if a frame is open.
  task automatic end_frame();
    int a;
    frame_last = 1'b1;
    if (in_frame) begin
      for (int r = 0; r < frame_dim; r++) begin
        for (int c = 0; c < frame_dim; c++) begin
          a = r * DIM + c;
          exp_q.push_back('{addr: a, data: model[a],
                            last: (r == frame_dim - 1) && (c == frame_dim - 1)});
        end
      end
      model_clear();
    end
    @(negedge clk);
    frame_last = 1'b0;
  endtask

  // Consume the drain stream against the queue. Optional stall window,
  // one injected input beat, or a reset at a given beat index.
  task automatic drain(input int stall_at, input int stall_len,
                       input int inject_at, input int rst_at);
    int nbeat    = 0;
    int stalled  = 0;
    int budget   = 0;
    bit injected = 1'b0;
    while (exp_q.size() > 0) begin
      if (budget >= 200) begin
        chk("drain_budget", budget, 0);
        exp_q.delete();
        break;
      end
      budget++;
      if (nbeat == rst_at) begin
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        break;
      end
      chk("out_valid", out_valid, 1);
      chk("out_addr", out_addr, exp_q[0].addr);
      chk("out_data", out_data, exp_q[0].data);
      chk("out_last", out_last, exp_q[0].last);
      if (nbeat == inject_at && !injected) begin
        in_valid = 1'b1;
        in_addr  = AW'(1);
        in_data  = 8'd50;
        injected = 1'b1;
      end
      if (nbeat == stall_at && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (out_ready) begin
        void'(exp_q.pop_front());
        nbeat++;
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop", drop, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_last", out_last, 0);

    // frame_last while idle is ignored
    end_frame();
    chk("idle_frame_last_busy", busy, 0);

    // Back-to-back beats to the same address sum up
    stride = 2'd1;
    send(7, 3);
    send(7, 4);
    chk("accum_busy", busy, 1);
    end_frame();
    chk("drain_busy", busy, 1);
    drain(-1, 0, -1, -1);
    chk("post_drain_busy", busy, 0);
    chk("post_drain_valid", out_valid, 0);

    // Stride 0 acts as 1; stall 5 cycles mid-drain; addr 4 lies outside the scan
    stride = 2'd0;
    send(0, 1);
    send(4, 9);
    send(21, 20);
    send(14, 6);
    send(14, 6);
    end_frame();
    drain(6, 5, -1, -1);

    // Stride 2 -> 5x5 scan includes addr 4, which must now read 0
    stride = 2'd2;
    send(10, 2);
    send(28, 5);
    end_frame();
    drain(-1, 0, -1, -1);

    // Stride 3 -> full 6x6 scan
    stride = 2'd3;
    send(35, 1);
    send(5, 2);
    end_frame();
    drain(-1, 0, -1, -1);
    chk("clean_ovf", ovf, 0);
    chk("clean_drop", drop, 0);

    // Out-of-range address is dropped
    stride = 2'd1;
    send(36, 5);
    chk("bad_addr_drop", drop, 1);
    send(1, 9);
    end_frame();
    drain(-1, 0, -1, -1);

    // Input during drain is discarded
    do_reset();
    chk("drop_cleared", drop, 0);
    send(1, 9);
    send(2, 1);
    end_frame();
    drain(-1, 0, 0, -1);
    chk("drain_input_drop", drop, 1);

    // Overflow: 200 + 100 into addr 0
    do_reset();
    chk("ovf_cleared", ovf, 0);
    send(0, 200);
    chk("ovf_before", ovf, 0);
    send(0, 100);
    chk("ovf_after", ovf, 1);
    end_frame();
    drain(-1, 0, -1, -1);
    chk("ovf_sticky", ovf, 1);

    // Reset at drain beat 5, then a fresh frame drains only its own data
    do_reset();
    send(0, 1);
    send(1, 2);
    send(20, 3);
    end_frame();
    drain(-1, 0, -1, 5);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    send(3, 4);
    end_frame();
    drain(-1, 0, -1, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
